// File: rtl/sort4_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sort4_stream_ctrl
//  Brief    : Collects up to four bytes from a valid/ready stream, pads short
//             groups, drives an external 4-input sort network through
//             registered lines, captures the sorted result and streams the
//             real elements back out in ascending order.
//  Revision : 1.0  initial release
// ============================================================================
module sort4_stream_ctrl #(
    parameter int            W   = 8,
    parameter logic [W-1:0]  PAD = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] sort_in1,
    output logic [W-1:0] sort_in2,
    output logic [W-1:0] sort_in3,
    output logic [W-1:0] sort_in4,
    input  logic [W-1:0] sort_out1,
    input  logic [W-1:0] sort_out2,
    input  logic [W-1:0] sort_out3,
    input  logic [W-1:0] sort_out4,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;        // elements collected, 0..4
    logic [1:0]     idx_q, idx_d;        // result index being presented
    logic [2:0]     n_q, n_d;            // real elements in the group, 1..4
    logic           last_flag_q, last_flag_d;
    logic [W-1:0]   slot_q [4];
    logic [W-1:0]   slot_d [4];
    logic [W-1:0]   res_q  [4];
    logic [W-1:0]   res_d  [4];
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [W-1:0]   out_data_q, out_data_d;

    logic           accept;
    logic           close_grp;
    logic [1:0]     idx_nxt;

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid && in_ready;
    // A group closes on the fourth element or on any accepted in_last.
    assign close_grp = accept && (in_last || (cnt_q == 3'd3));
    assign idx_nxt   = idx_q + 2'd1;

    assign sort_in1  = slot_q[0];
    assign sort_in2  = slot_q[1];
    assign sort_in3  = slot_q[2];
    assign sort_in4  = slot_q[3];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != FILL) || (cnt_q != 3'd0);

    // Next-state and next-register computation for the fill/sort/drain sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        n_d         = n_q;
        last_flag_d = last_flag_q;
        slot_d      = slot_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + 3'd1;
                    // Write the new element; on close, fill the unused tail
                    // with PAD so it sorts behind every real value.
                    for (int i = 0; i < 4; i++) begin
                        if (3'(i) == cnt_q) begin
                            slot_d[i] = in_data;
                        end else if (close_grp && (3'(i) > cnt_q)) begin
                            slot_d[i] = PAD;
                        end
                    end
                    if (close_grp) begin
                        n_d         = cnt_q + 3'd1;
                        last_flag_d = in_last;
                        state_d     = SORT;
                    end
                end
            end
            SORT: begin
                // Network inputs have been stable for a full cycle.
                res_d[0]    = sort_out1;
                res_d[1]    = sort_out2;
                res_d[2]    = sort_out3;
                res_d[3]    = sort_out4;
                idx_d       = 2'd0;
                out_valid_d = 1'b1;
                out_data_d  = sort_out1;
                out_last_d  = last_flag_q && (n_q == 3'd1);
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if ({1'b0, idx_q} == (n_q - 3'd1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        cnt_d       = 3'd0;
                        state_d     = FILL;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = res_q[idx_nxt];
                        out_last_d = last_flag_q && ({1'b0, idx_nxt} == (n_q - 3'd1));
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= 3'd0;
            idx_q       <= 2'd0;
            n_q         <= 3'd0;
            last_flag_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
                res_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            last_flag_q <= last_flag_d;
            slot_q      <= slot_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
`default_nettype wire
